// File: rtl/mc_ctrl_if.sv
// Data-memory request/ready handshake between the multi-cycle controller
// and the data memory.
interface mc_ctrl_if;
  logic mem_req;
  logic mem_write;
  logic mem_rdy;

  modport master (output mem_req, output mem_write, input mem_rdy);
  modport slave  (input mem_req, input mem_write, output mem_rdy);
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle controller for the MIPS subset: sequences FETCH/DECODE/EXEC/MEM/WB,
// gates write enables by state, bounds data-memory waits and counts retires.
module mc_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic [1:0]       cmp,
  input  logic [1:0]       zero,
  mc_ctrl_if.master        mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic [2:0]       NPCop,
  output logic             reg_write,
  output logic [2:0]       reg_dst,
  output logic [2:0]       which_to_reg,
  output logic [1:0]       ALU_src,
  output logic [4:0]       ALU_op,
  output logic [1:0]       LS_op,
  output logic             sign,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_ERR  = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    K_NOP, K_ALU, K_LOAD, K_STORE, K_BEQ, K_BLEZ, K_J, K_JR, K_JAL, K_JALR
  } kind_e;

  localparam logic [2:0] NPC_PC4 = 3'd0, NPC_B = 3'd1, NPC_J = 3'd2, NPC_JR = 3'd3;

  state_e              r_state, w_next_state;
  kind_e               w_kind;
  logic [WAIT_W-1:0]   r_wait, w_wait_next;
  logic                r_bus_err;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_ir_write, w_pc_write, w_reg_write, w_mem_req, w_mem_write;
  logic [2:0]          w_npc;

  // Field decode is purely a function of the instruction; only enables depend on state.
  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_kind       = K_NOP;
    reg_dst      = 3'd0;
    which_to_reg = 3'd0;
    ALU_src      = 2'd0;
    ALU_op       = 5'd0;
    LS_op        = 2'd0;
    sign         = 1'b1;
    if (opcode == 6'h00) begin
      reg_dst = 3'd1;
      case (func)
        6'h21: begin w_kind = K_ALU; ALU_op = 5'd0; end
        6'h23: begin w_kind = K_ALU; ALU_op = 5'd1; end
        6'h24: begin w_kind = K_ALU; ALU_op = 5'd2; end
        6'h25: begin w_kind = K_ALU; ALU_op = 5'd3; end
        6'h2a: begin w_kind = K_ALU; ALU_op = 5'd4; end
        6'h04: begin w_kind = K_ALU; ALU_op = 5'd6; end
        6'h08: w_kind = K_JR;
        6'h09: begin w_kind = K_JALR; which_to_reg = 3'd2; end
        default: ;
      endcase
    end else begin
      case (opcode)
        6'h02: w_kind = K_J;
        6'h03: begin w_kind = K_JAL; reg_dst = 3'd2; which_to_reg = 3'd2; end
        6'h04: w_kind = K_BEQ;
        6'h06: w_kind = K_BLEZ;
        6'h09: begin w_kind = K_ALU; ALU_src = 2'd1; ALU_op = 5'd0; end
        6'h0a: begin w_kind = K_ALU; ALU_src = 2'd1; ALU_op = 5'd4; end
        6'h0c: begin w_kind = K_ALU; ALU_src = 2'd1; ALU_op = 5'd2; sign = 1'b0; end
        6'h0d: begin w_kind = K_ALU; ALU_src = 2'd1; ALU_op = 5'd3; sign = 1'b0; end
        6'h0f: begin w_kind = K_ALU; ALU_src = 2'd1; ALU_op = 5'd5; end
        6'h23: begin w_kind = K_LOAD;  ALU_src = 2'd1; which_to_reg = 3'd1; LS_op = 2'd0; end
        6'h21: begin w_kind = K_LOAD;  ALU_src = 2'd1; which_to_reg = 3'd1; LS_op = 2'd1; end
        6'h25: begin w_kind = K_LOAD;  ALU_src = 2'd1; which_to_reg = 3'd1; LS_op = 2'd1; end
        6'h20: begin w_kind = K_LOAD;  ALU_src = 2'd1; which_to_reg = 3'd1; LS_op = 2'd2; end
        6'h2b: begin w_kind = K_STORE; ALU_src = 2'd1; LS_op = 2'd0; end
        6'h29: begin w_kind = K_STORE; ALU_src = 2'd1; LS_op = 2'd1; end
        6'h28: begin w_kind = K_STORE; ALU_src = 2'd1; LS_op = 2'd2; end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_wait_next  = r_wait;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_npc        = NPC_PC4;
    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        case (w_kind)
          K_BEQ:  if (cmp == 2'b01) w_npc = NPC_B;
          K_BLEZ: if (zero == 2'b01 || zero == 2'b10) w_npc = NPC_B;
          K_J:    w_npc = NPC_J;
          K_JR:   w_npc = NPC_JR;
          default: ;
        endcase
        case (w_kind)
          K_LOAD, K_STORE:     w_next_state = S_MEM;
          K_ALU, K_JAL, K_JALR: w_next_state = S_WB;
          default: begin
            w_pc_write   = 1'b1;
            w_next_state = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        w_mem_req   = 1'b1;
        w_mem_write = (w_kind == K_STORE);
        if (mem.mem_rdy) begin
          // A ready arriving on the timeout cycle still completes the access.
          w_wait_next = '0;
          if (w_kind == K_LOAD) begin
            w_next_state = S_WB;
          end else begin
            w_pc_write   = 1'b1;
            w_next_state = S_FETCH;
          end
        end else if (TIMEOUT != 0) begin
          if (r_wait == WAIT_W'(TIMEOUT)) begin
            w_wait_next  = '0;
            w_next_state = S_ERR;
          end else begin
            w_wait_next = r_wait + 1'b1;
          end
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        if (w_kind == K_JAL)  w_npc = NPC_J;
        if (w_kind == K_JALR) w_npc = NPC_JR;
        w_next_state = S_FETCH;
      end
      S_ERR:   w_next_state = S_ERR;
      default: w_next_state = S_FETCH;
    endcase
    // Enables must stay low for the whole reset cycle, whatever state we sit in.
    if (reset) begin
      w_ir_write  = 1'b0;
      w_pc_write  = 1'b0;
      w_reg_write = 1'b0;
      w_mem_req   = 1'b0;
      w_mem_write = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next_state;
      r_wait  <= w_wait_next;
      if (w_next_state == S_ERR) r_bus_err <= 1'b1;
      if (w_pc_write)            r_cnt     <= r_cnt + 1'b1;
    end
  end

  assign ir_write      = w_ir_write;
  assign pc_write      = w_pc_write;
  assign reg_write     = w_reg_write;
  assign NPCop         = w_npc;
  assign mem.mem_req   = w_mem_req;
  assign mem.mem_write = w_mem_write;
  assign instr_done    = w_pc_write;
  assign state         = r_state;
  assign bus_err       = r_bus_err;
  assign instr_cnt     = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus random instruction
// streams compared cycle by cycle against an instruction-level reference model.
module tb_mc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [5:0] opcode, func;
  logic [1:0] cmp, zero;
  logic       mem_rdy;

  mc_ctrl_if mem_bus ();
  mc_ctrl_if mem_bus4 ();
  assign mem_bus.mem_rdy  = mem_rdy;
  assign mem_bus4.mem_rdy = mem_rdy;

  logic        ir_write, pc_write, reg_write, sign, instr_done, bus_err;
  logic [2:0]  NPCop, reg_dst, which_to_reg, state;
  logic [1:0]  ALU_src, LS_op;
  logic [4:0]  ALU_op;
  logic [31:0] instr_cnt;

  logic        ir_write4, pc_write4, reg_write4, sign4, instr_done4, bus_err4;
  logic [2:0]  NPCop4, reg_dst4, which_to_reg4, state4;
  logic [1:0]  ALU_src4, LS_op4;
  logic [4:0]  ALU_op4;
  logic [3:0]  instr_cnt4;

  mc_ctrl #(.TIMEOUT(15), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .cmp(cmp), .zero(zero),
    .mem(mem_bus), .ir_write(ir_write), .pc_write(pc_write), .NPCop(NPCop),
    .reg_write(reg_write), .reg_dst(reg_dst), .which_to_reg(which_to_reg),
    .ALU_src(ALU_src), .ALU_op(ALU_op), .LS_op(LS_op), .sign(sign), .state(state),
    .instr_done(instr_done), .bus_err(bus_err), .instr_cnt(instr_cnt)
  );

  mc_ctrl #(.TIMEOUT(15), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .cmp(cmp), .zero(zero),
    .mem(mem_bus4), .ir_write(ir_write4), .pc_write(pc_write4), .NPCop(NPCop4),
    .reg_write(reg_write4), .reg_dst(reg_dst4), .which_to_reg(which_to_reg4),
    .ALU_src(ALU_src4), .ALU_op(ALU_op4), .LS_op(LS_op4), .sign(sign4), .state(state4),
    .instr_done(instr_done4), .bus_err(bus_err4), .instr_cnt(instr_cnt4)
  );

  typedef enum logic [3:0] {
    T_NOP, T_ALU, T_LOAD, T_STORE, T_BEQ, T_BLEZ, T_J, T_JR, T_JAL, T_JALR
  } tkind_e;

  typedef struct {
    tkind_e     kind;
    logic [2:0] reg_dst;
    logic [2:0] wtr;
    logic [4:0] alu_op;
    logic [1:0] alu_src;
    logic [1:0] ls_op;
    logic       sign;
  } ref_t;

  localparam logic [11:0] OPS [0:27] = '{
    {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h24}, {6'h00, 6'h25},
    {6'h00, 6'h2a}, {6'h00, 6'h04}, {6'h00, 6'h08}, {6'h00, 6'h09},
    {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h04, 6'h00}, {6'h06, 6'h00},
    {6'h09, 6'h00}, {6'h0a, 6'h00}, {6'h0c, 6'h00}, {6'h0d, 6'h00},
    {6'h0f, 6'h00}, {6'h23, 6'h00}, {6'h21, 6'h00}, {6'h20, 6'h00},
    {6'h25, 6'h00}, {6'h2b, 6'h00}, {6'h29, 6'h00}, {6'h28, 6'h00},
    {6'h3f, 6'h00}, {6'h00, 6'h00}, {6'h05, 6'h00}, {6'h00, 6'h3f}
  };

  int n_cmp  = 0;
  int n_fail = 0;
  int model_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction-set table: what each mnemonic means to the datapath.
  function automatic ref_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
    ref_t r;
    r.kind = T_NOP; r.wtr = 3'd0; r.alu_op = 5'd0; r.alu_src = 2'd0;
    r.ls_op = 2'd0; r.sign = 1'b1;
    r.reg_dst = (op == 6'h00) ? 3'd1 : (op == 6'h03) ? 3'd2 : 3'd0;
    if (op == 6'h00) begin
      case (fn)
        6'h21: begin r.kind = T_ALU; r.alu_op = 5'd0; end  // addu
        6'h23: begin r.kind = T_ALU; r.alu_op = 5'd1; end  // subu
        6'h24: begin r.kind = T_ALU; r.alu_op = 5'd2; end  // and
        6'h25: begin r.kind = T_ALU; r.alu_op = 5'd3; end  // or
        6'h2a: begin r.kind = T_ALU; r.alu_op = 5'd4; end  // slt
        6'h04: begin r.kind = T_ALU; r.alu_op = 5'd6; end  // sllv
        6'h08: r.kind = T_JR;
        6'h09: begin r.kind = T_JALR; r.wtr = 3'd2; end
        default: ;
      endcase
    end else begin
      case (op)
        6'h02: r.kind = T_J;
        6'h03: begin r.kind = T_JAL; r.wtr = 3'd2; end
        6'h04: r.kind = T_BEQ;
        6'h06: r.kind = T_BLEZ;
        6'h09: begin r.kind = T_ALU; r.alu_src = 2'd1; r.alu_op = 5'd0; end
        6'h0a: begin r.kind = T_ALU; r.alu_src = 2'd1; r.alu_op = 5'd4; end
        6'h0c: begin r.kind = T_ALU; r.alu_src = 2'd1; r.alu_op = 5'd2; r.sign = 1'b0; end
        6'h0d: begin r.kind = T_ALU; r.alu_src = 2'd1; r.alu_op = 5'd3; r.sign = 1'b0; end
        6'h0f: begin r.kind = T_ALU; r.alu_src = 2'd1; r.alu_op = 5'd5; end
        6'h23: begin r.kind = T_LOAD; r.alu_src = 2'd1; r.wtr = 3'd1; r.ls_op = 2'd0; end
        6'h21, 6'h25: begin r.kind = T_LOAD; r.alu_src = 2'd1; r.wtr = 3'd1; r.ls_op = 2'd1; end
        6'h20: begin r.kind = T_LOAD; r.alu_src = 2'd1; r.wtr = 3'd1; r.ls_op = 2'd2; end
        6'h2b: begin r.kind = T_STORE; r.alu_src = 2'd1; r.ls_op = 2'd0; end
        6'h29: begin r.kind = T_STORE; r.alu_src = 2'd1; r.ls_op = 2'd1; end
        6'h28: begin r.kind = T_STORE; r.alu_src = 2'd1; r.ls_op = 2'd2; end
        default: ;
      endcase
    end
    return r;
  endfunction

  function automatic logic [2:0] ref_npc(input tkind_e k, input logic [1:0] c, input logic [1:0] z);
    case (k)
      T_BEQ:          return (c == 2'b01) ? 3'd1 : 3'd0;
      T_BLEZ:         return (z == 2'b01 || z == 2'b10) ? 3'd1 : 3'd0;
      T_J, T_JAL:     return 3'd2;
      T_JR, T_JALR:   return 3'd3;
      default:        return 3'd0;
    endcase
  endfunction

  task automatic check_cycle(input int st, input bit last, input ref_t r, input logic [2:0] npc);
    logic [6:0] en_exp;
    en_exp = {st == 0, last, st == 4, st == 3, (st == 3) && (r.kind == T_STORE), last, 1'b0};
    chk("state", state, st);
    chk("state4", state4, st);
    chk("enables", {ir_write, pc_write, reg_write, mem_bus.mem_req, mem_bus.mem_write,
                    instr_done, bus_err}, en_exp);
    chk("enables4", {ir_write4, pc_write4, reg_write4, mem_bus4.mem_req, mem_bus4.mem_write,
                     instr_done4, bus_err4}, en_exp);
    chk("instr_cnt", instr_cnt, model_cnt);
    chk("instr_cnt4", instr_cnt4, model_cnt % 16);
    if (last || st == 2) begin
      chk("NPCop", NPCop, last ? npc : 3'd0);
      chk("NPCop4", NPCop4, last ? npc : 3'd0);
    end
    if (st == 2) begin
      chk("reg_dst", reg_dst, r.reg_dst);
      chk("which_to_reg", which_to_reg, r.wtr);
      chk("ALU_op", ALU_op, r.alu_op);
      chk("ALU_src", ALU_src, r.alu_src);
      chk("LS_op", LS_op, r.ls_op);
      chk("sign", sign, r.sign);
      chk("fields4", {reg_dst4, which_to_reg4, ALU_op4, ALU_src4, LS_op4, sign4},
          {r.reg_dst, r.wtr, r.alu_op, r.alu_src, r.ls_op, r.sign});
    end
  endtask

  // Runs one instruction to retirement; mem_rdy rises after 'waits' idle MEM cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [1:0] c, input logic [1:0] z, input int waits);
    ref_t r;
    int   st_q[$];
    r = ref_decode(op, fn);
    st_q = {0, 1, 2};
    if (r.kind == T_LOAD || r.kind == T_STORE) begin
      repeat (waits + 1) st_q.push_back(3);
      if (r.kind == T_LOAD) st_q.push_back(4);
    end else if (r.kind == T_ALU || r.kind == T_JAL || r.kind == T_JALR) begin
      st_q.push_back(4);
    end
    opcode = op; func = fn; cmp = c; zero = z;
    for (int i = 0; i < st_q.size(); i++) begin
      mem_rdy = (st_q[i] == 3) && (i == 3 + waits);
      #1;
      check_cycle(st_q[i], i == st_q.size() - 1, r, ref_npc(r.kind, c, z));
      @(posedge clk); #2;
    end
    mem_rdy = 1'b0;
    model_cnt++;
  endtask

  task automatic do_reset(input bit chk_during);
    reset = 1'b1;
    mem_rdy = 1'b0;
    if (chk_during) begin
      #1;
      chk("rst_cycle_en", {ir_write, pc_write, reg_write, mem_bus.mem_req, mem_bus.mem_write,
                           instr_done}, 6'd0);
      chk("rst_cycle_en4", {ir_write4, pc_write4, reg_write4, mem_bus4.mem_req,
                            mem_bus4.mem_write, instr_done4}, 6'd0);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    model_cnt = 0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_en", {ir_write, pc_write, reg_write, mem_bus.mem_req, mem_bus.mem_write,
                   instr_done, bus_err}, 7'b1000000);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_cnt4", instr_cnt4, 0);
    chk("rst_bus_err4", bus_err4, 0);
  endtask

  initial begin
    ref_t r;
    logic [11:0] pick;
    logic [5:0]  fn;
    reset = 1'b1; opcode = '0; func = '0; cmp = '0; zero = '0; mem_rdy = 1'b0;
    @(posedge clk);
    do_reset(1'b0);

    run_instr(6'h00, 6'h21, 2'b00, 2'b00, 0);       // addu
    chk("addu_cnt", instr_cnt, 1);
    run_instr(6'h23, 6'h00, 2'b00, 2'b00, 3);       // lw, three wait cycles
    run_instr(6'h04, 6'h00, 2'b01, 2'b00, 0);       // beq taken
    run_instr(6'h04, 6'h00, 2'b00, 2'b00, 0);       // beq not taken
    run_instr(6'h06, 6'h00, 2'b00, 2'b01, 0);       // blez rs==0
    run_instr(6'h06, 6'h00, 2'b00, 2'b10, 0);       // blez rs<0
    run_instr(6'h06, 6'h00, 2'b00, 2'b00, 0);       // blez rs>0

    // sw with mem_rdy never arriving: 16 MEM cycles, then sticky ERR.
    r = ref_decode(6'h2b, 6'h00);
    opcode = 6'h2b; func = 6'h00; mem_rdy = 1'b0;
    for (int i = 0; i < 19; i++) begin
      #1;
      check_cycle((i < 3) ? i : 3, 1'b0, r, 3'd0);
      @(posedge clk); #2;
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("err_state", state, 7);
      chk("err_en", {ir_write, pc_write, reg_write, mem_bus.mem_req, mem_bus.mem_write,
                     instr_done, bus_err}, 7'b0000001);
      chk("err_en4", {ir_write4, pc_write4, reg_write4, mem_bus4.mem_req, mem_bus4.mem_write,
                      instr_done4, bus_err4}, 7'b0000001);
      @(posedge clk); #2;
    end
    do_reset(1'b1);

    run_instr(6'h2b, 6'h00, 2'b00, 2'b00, 15);      // ready on the timeout cycle
    run_instr(6'h2b, 6'h00, 2'b00, 2'b00, 14);
    run_instr(6'h03, 6'h00, 2'b00, 2'b00, 0);       // jal
    run_instr(6'h00, 6'h09, 2'b00, 2'b00, 0);       // jalr
    run_instr(6'h00, 6'h08, 2'b00, 2'b00, 0);       // jr

    // Reset landing in the middle of an sb wait.
    r = ref_decode(6'h28, 6'h00);
    opcode = 6'h28; func = 6'h00; mem_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_cycle((i < 3) ? i : 3, 1'b0, r, 3'd0);
      @(posedge clk); #2;
    end
    do_reset(1'b1);

    // Sixteen retires wrap the 4-bit counter back to zero.
    for (int n = 0; n < 16; n++) begin
      pick = OPS[$urandom_range(27)];
      fn = (pick[11:6] == 6'h00) ? pick[5:0] : 6'($urandom);
      run_instr(pick[11:6], fn, 2'($urandom), 2'($urandom), $urandom_range(2));
    end
    #1;
    chk("wrap_cnt4", instr_cnt4, 0);
    chk("wrap_cnt", instr_cnt, 16);

    for (int n = 0; n < 60; n++) begin
      pick = OPS[$urandom_range(27)];
      fn = (pick[11:6] == 6'h00) ? pick[5:0] : 6'($urandom);
      run_instr(pick[11:6], fn, 2'($urandom), 2'($urandom), $urandom_range(4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle controller FSM; successor to the single-cycle decoder.
- Same instruction set: addu subu and or slt sllv jr jalr j jal beq blez addiu slti andi ori lui lw lh lb lhu sw sh sb.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and gates every write enable by state.
- Adds a data-memory req/rdy handshake with a bounded wait and a sticky bus-error state, plus a retired-instruction counter.

Parameters:
- TIMEOUT, 15: max cycles waiting in MEM for mem_rdy; 0 = wait forever.
- CNT_W, 32: width of instr_cnt.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- func  in  6  IR[5:0].
- cmp  in  2  01 = rs==rt, else not equal.
- zero  in  2  01 = rs==0, 10 = rs<0, 00 = rs>0.
- mem_rdy  in  1  data memory completes the access this cycle.
- ir_write  out  1  latch IR.
- pc_write  out  1  PC <= NPC.
- NPCop  out  3  0 = PC4, 1 = B, 2 = J, 3 = JR.
- reg_write  out  1  GPR write enable.
- reg_dst  out  3  0 = rt, 1 = rd, 2 = $31.
- which_to_reg  out  3  0 = ALU result, 1 = DM, 2 = PC+4.
- ALU_src  out  2  0 = RD2, 1 = imm32.
- ALU_op  out  5  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lui, 6 sllv.
- LS_op  out  2  0 = word, 1 = half, 2 = byte.
- sign  out  1  0 = zero-extend, 1 = sign-extend.
- mem_req  out  1  data-memory request.
- mem_write  out  1  store strobe.
- state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, ERR 7.
- instr_done  out  1  one-cycle retire pulse.
- bus_err  out  1  sticky timeout flag.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (synchronous, active-high):
  - state = FETCH, wait counter = 0, bus_err = 0, instr_cnt = 0.
  - During the reset cycle all of ir_write, pc_write, reg_write, mem_req, mem_write, instr_done = 0.
  - Reset overrides every state, including MEM mid-wait and ERR.
- Field decode (combinational from opcode/func, identical to the single-cycle mapping):
  - reg_dst: R-type → rd, jal → $31, else rt.
  - which_to_reg: loads → DM, jal/jalr → PC+4, else ALU result.
  - sign = 0 for ori/andi, 1 otherwise.
  - ALU_src = imm32 for I-type ALU ops and all loads/stores.
  - LS_op: w for lw/sw, h for lh/sh/lhu, b for lb/sb.
  - Enables are asserted only in the states listed below.
- FETCH:
  - ir_write = 1.
  - Next state DECODE.
- DECODE:
  - No enables.
  - Next state EXEC.
- EXEC:
  - Loads/stores → MEM.
  - ALU ops, jal, jalr → WB.
  - beq/blez/j/jr/unknown are final here: pc_write = 1.
  - NPCop in EXEC: beq with cmp==01 → B; blez with zero 01 or 10 → B; j → J; jr → JR; else PC4.
  - Next state FETCH.
- MEM:
  - mem_req = 1 each cycle in MEM; mem_write = 1 for stores.
  - Wait counter increments while !mem_rdy.
  - On mem_rdy: loads → WB; stores final (pc_write = 1, NPCop PC4) → FETCH; counter cleared.
  - If counter == TIMEOUT (TIMEOUT ≠ 0) and !mem_rdy → ERR.
  - mem_rdy in the same cycle as the timeout wins (no error).
- WB:
  - reg_write = 1, pc_write = 1.
  - NPCop = J for jal, JR for jalr, else PC4.
  - Next state FETCH.
- ERR:
  - All enables 0, bus_err = 1; held until reset.
- Retire:
  - instr_done = pc_write.
  - instr_cnt += 1 on each pc_write; wraps modulo 2^CNT_W.
- Unknown opcode/func:
  - Executed as nop (3 cycles, PC4, no reg/mem write).
- Latency with mem_rdy asserted on the first MEM cycle:
  - R/I ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/blez/j/jr: 3 cycles.
  - jal/jalr: 4 cycles.
  - Each mem_rdy wait cycle adds 1.

Test Plan:
- Reset, then addu (opcode 0, func 0x21):
  - state sequence 0,1,2,4,0; reg_write=1 and pc_write=1 only in WB.
  - reg_dst=1, ALU_op=0; instr_cnt=1.
- lw (0x23), mem_rdy low 3 cycles:
  - MEM held 4 cycles with mem_req=1, mem_write=0.
  - Then WB with which_to_reg=1, LS_op=0; total 8 cycles.
- beq (0x04): cmp=01 → EXEC has pc_write=1, NPCop=1. cmp=00 → NPCop=0. Both take 3 cycles, reg_write never set.
- sw (0x2b), TIMEOUT=15:
  - mem_rdy never asserted → ERR after 16 MEM cycles; bus_err=1, enables 0.
  - Reset → state 0, bus_err 0, instr_cnt 0.
  - Repeat with mem_rdy asserted on the 16th MEM cycle → no error, pc_write=1.
- jal (0x03):
  - WB has reg_dst=2, which_to_reg=2, NPCop=2.
  - jalr (func 0x09): reg_dst=1, NPCop=3.
- Reset asserted mid-MEM of sb (0x28):
  - Next cycle state=0, mem_req=0, mem_write=0, no pc_write.
  - CNT_W=4: 16 retires wrap instr_cnt to 0.
